// File: rtl/bn_stream_pkg.sv
// Stream types shared by the batch-normalization split/merge blocks.
// The select encoding here is the one the 1-to-3 demultiplexer decodes.
package bn_stream_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_CH0 = 2'b00;
    localparam sel_t SEL_CH1 = 2'b01;
    localparam sel_t SEL_CH2 = 2'b10;

    typedef enum logic {
        LOCK_IDLE,
        LOCK_LOCKED
    } lock_state_e;

    // Grants are one-hot; an all-zero grant maps to SEL_CH0 and is never used.
    function automatic sel_t onehot_to_sel(input logic [2:0] oh);
        sel_t s;
        if (oh[2])      s = SEL_CH2;
        else if (oh[1]) s = SEL_CH1;
        else            s = SEL_CH0;
        return s;
    endfunction

    function automatic logic [2:0] sel_to_mask(input sel_t s);
        logic [2:0] m;
        case (s)
            SEL_CH0: m = 3'b001;
            SEL_CH1: m = 3'b010;
            SEL_CH2: m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rr_arb_3.sv
// Combinational 3-way round-robin arbiter: the channel after rr_ptr
// has highest priority, searching cyclically 0 -> 1 -> 2 -> 0.
module rr_arb_3
    import bn_stream_pkg::*;
(
    input  logic [2:0] req,
    input  sel_t       rr_ptr,
    input  logic       en,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        if (en) begin
            case (rr_ptr)
                SEL_CH0: begin
                    if (req[1])      gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                end
                SEL_CH1: begin
                    if (req[2])      gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                end
                // The unused code 2'b11 behaves like SEL_CH2 (ch0 first).
                default: begin
                    if (req[0])      gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                end
            endcase
        end
    end

endmodule

// File: rtl/merge_3_1.sv
// Three-input round-robin stream merger with a single registered output slot.
// Define MERGE_BURST_LOCK_EN to hold the grant on one channel until its in_last beat.
module merge_3_1
    import bn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            in_valid,
    output logic [2:0]            in_ready,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic [DATA_WIDTH-1:0] in2_data,
    input  logic [2:0]            in_last,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output sel_t                  o_sel,
    output logic                  o_last
);

    logic                  o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0] o_data_q,  o_data_d;
    sel_t                  o_sel_q,   o_sel_d;
    logic                  o_last_q,  o_last_d;
    sel_t                  rr_ptr_q,  rr_ptr_d;

    logic       load_ok;
    logic [2:0] req;
    logic [2:0] gnt;
    logic       transfer;
    sel_t       gnt_sel;
    logic       gnt_last;

    assign load_ok  = !o_valid_q || o_ready;
    assign transfer = |(gnt & in_valid);
    assign gnt_sel  = onehot_to_sel(gnt);
    assign gnt_last = |(gnt & in_last);
    assign in_ready = gnt;

`ifdef MERGE_BURST_LOCK_EN
    lock_state_e lock_state_q, lock_state_d;
    sel_t        lock_ch_q,    lock_ch_d;

    // While locked, every channel except the owner of the burst is masked off.
    always_comb begin
        req = in_valid;
        if (lock_state_q == LOCK_LOCKED) begin
            req = in_valid & sel_to_mask(lock_ch_q);
        end
    end

    always_comb begin
        lock_state_d = lock_state_q;
        lock_ch_d    = lock_ch_q;
        case (lock_state_q)
            LOCK_IDLE: begin
                if (transfer && !gnt_last) begin
                    lock_state_d = LOCK_LOCKED;
                    lock_ch_d    = gnt_sel;
                end
            end
            LOCK_LOCKED: begin
                if (transfer && gnt_last) begin
                    lock_state_d = LOCK_IDLE;
                end
            end
            default: lock_state_d = LOCK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state_q <= LOCK_IDLE;
            lock_ch_q    <= SEL_CH0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_ch_q    <= lock_ch_d;
        end
    end
`else
    assign req = in_valid;
`endif

    rr_arb_3 u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .en     (load_ok && !rst),
        .gnt    (gnt)
    );

    // Loading and draining in the same cycle keeps the slot full: no bubble.
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_sel_d   = o_sel_q;
        o_last_d  = o_last_q;
        rr_ptr_d  = rr_ptr_q;
        if (transfer) begin
            o_valid_d = 1'b1;
            o_sel_d   = gnt_sel;
            o_last_d  = gnt_last;
            rr_ptr_d  = gnt_sel;
            case (gnt_sel)
                SEL_CH1: o_data_d = in1_data;
                SEL_CH2: o_data_d = in2_data;
                default: o_data_d = in0_data;
            endcase
        end else if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_sel_q   <= SEL_CH0;
            o_last_q  <= 1'b0;
            rr_ptr_q  <= SEL_CH2;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_sel_q   <= o_sel_d;
            o_last_q  <= o_last_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_sel   = o_sel_q;
    assign o_last  = o_last_q;

endmodule

// File: tb/tb_merge_3_1.sv
// Self-checking bench for merge_3_1: directed scenarios then random traffic,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_merge_3_1;

    import bn_stream_pkg::*;

    localparam int DW = 16;
`ifdef MERGE_BURST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    in_valid = 3'b000;
    logic [2:0]    in_ready;
    logic [DW-1:0] in0_data = '0;
    logic [DW-1:0] in1_data = '0;
    logic [DW-1:0] in2_data = '0;
    logic [2:0]    in_last = 3'b000;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [DW-1:0] o_data;
    sel_t          o_sel;
    logic          o_last;

    always #5 clk = ~clk;

    merge_3_1 #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in0_data (in0_data),
        .in1_data (in1_data),
        .in2_data (in2_data),
        .in_last  (in_last),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_sel    (o_sel),
        .o_last   (o_last)
    );

    // Pending beats per source channel; the head beat is what the channel presents.
    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];

    // Reference model of the output slot and arbitration state.
    logic          m_valid   = 1'b0;
    logic [DW-1:0] m_data    = '0;
    int            m_sel     = 0;
    logic          m_last    = 1'b0;
    int            m_ptr     = 2;
    bit            m_locked  = 1'b0;
    int            m_lock_ch = 0;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int qSize(input int ch);
        case (ch)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic beat_t qHead(input int ch);
        beat_t b;
        b = '0;
        case (ch)
            0: if (q0.size() != 0) b = q0[0];
            1: if (q1.size() != 0) b = q1[0];
            default: if (q2.size() != 0) b = q2[0];
        endcase
        return b;
    endfunction

    task automatic qPop(input int ch);
        case (ch)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic qPush(input int ch, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        case (ch)
            0: q0.push_back(b);
            1: q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic qClear();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Which channel the model expects to win this cycle, or -1 for none.
    function automatic int modelGrant(input logic [2:0] v, input logic r, input logic rdy);
        if (r) return -1;
        if (m_valid && !rdy) return -1;
        for (int k = 1; k <= 3; k++) begin
            int ch;
            ch = (m_ptr + k) % 3;
            if (v[ch] && (!m_locked || ch == m_lock_ch)) return ch;
        end
        return -1;
    endfunction

    // One clock: drive at negedge, check in_ready, clock, update model, check outputs.
    task automatic applyStimulus(input logic rst_v, input logic rdy_v);
        int    g;
        beat_t b;
        logic [2:0] exp_rdy;
        @(negedge clk);
        rst     = rst_v;
        o_ready = rdy_v;
        for (int c = 0; c < 3; c++) begin
            in_valid[c] = (qSize(c) != 0);
            in_last[c]  = qHead(c).last;
        end
        in0_data = qHead(0).data;
        in1_data = qHead(1).data;
        in2_data = qHead(2).data;
        #1;
        g = modelGrant(in_valid, rst_v, rdy_v);
        exp_rdy = (g < 0) ? 3'b000 : (3'b001 << g);
        checkOutput("in_ready", {29'b0, in_ready}, {29'b0, exp_rdy});
        @(posedge clk);
        #1;
        if (rst_v) begin
            m_valid  = 1'b0;
            m_data   = '0;
            m_sel    = 0;
            m_last   = 1'b0;
            m_ptr    = 2;
            m_locked = 1'b0;
        end else if (g >= 0) begin
            b       = qHead(g);
            m_valid = 1'b1;
            m_data  = b.data;
            m_sel   = g;
            m_last  = b.last;
            m_ptr   = g;
            if (LOCK_EN) begin
                if (!m_locked && !b.last) begin
                    m_locked  = 1'b1;
                    m_lock_ch = g;
                end else if (m_locked && b.last) begin
                    m_locked = 1'b0;
                end
            end
            qPop(g);
        end else if (m_valid && rdy_v) begin
            m_valid = 1'b0;
        end
        checkOutput("o_valid", {31'b0, o_valid}, {31'b0, m_valid});
        checkOutput("o_data",  {16'b0, o_data},  {16'b0, m_data});
        checkOutput("o_sel",   {30'b0, o_sel},   m_sel);
        checkOutput("o_last",  {31'b0, o_last},  {31'b0, m_last});
    endtask

`ifdef MERGE_BURST_LOCK_EN
    int burst_exp[5] = '{0, 0, 0, 2, 2};
`else
    int burst_exp[5] = '{0, 2, 0, 2, 0};
`endif
    int rr_exp[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        logic [DW-1:0] held;

        // Reset values.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_o_valid", {31'b0, o_valid}, 32'd0);
        checkOutput("reset_o_sel",   {30'b0, o_sel},   32'd0);
        checkOutput("reset_o_data",  {16'b0, o_data},  32'd0);

        // All channels valid: strict rotation starting at ch0.
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 3; c++) qPush(c, DW'(16'h1000 + i * 16 + c), 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("rr_sequence", {30'b0, o_sel}, rr_exp[i]);
        end

        // Only ch1 valid, streaming at full rate.
        qClear();
        applyStimulus(1'b0, 1'b1);
        qPush(1, 16'h00A5, 1'b0);
        qPush(1, 16'h00A6, 1'b0);
        qPush(1, 16'h00A7, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ch1_data", {16'b0, o_data}, 32'h00A5);
        checkOutput("ch1_sel",  {30'b0, o_sel},  32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ch1_rate", {16'b0, o_data}, 32'h00A6);
        applyStimulus(1'b0, 1'b1);

        // Back-pressure with a full slot: no grants, stable output.
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 3; c++) qPush(c, DW'(16'h2000 + i * 16 + c), 1'b1);
        end
        applyStimulus(1'b0, 1'b1);
        held = o_data;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("stall_data", {16'b0, o_data}, {16'b0, held});
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);

        // Burst from ch0 competing with ch2.
        qClear();
        applyStimulus(1'b1, 1'b1);
        qPush(0, 16'h3001, 1'b0);
        qPush(0, 16'h3002, 1'b0);
        qPush(0, 16'h3003, 1'b1);
        for (int i = 0; i < 5; i++) qPush(2, DW'(16'h3200 + i), 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("burst_sequence", {30'b0, o_sel}, burst_exp[i]);
        end

        // Reset in the middle of a burst with a held beat.
        qClear();
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            qPush(0, DW'(16'h4000 + i), 1'b0);
            qPush(1, DW'(16'h4100 + i), 1'b1);
            qPush(2, DW'(16'h4200 + i), 1'b1);
        end
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst_o_valid", {31'b0, o_valid}, 32'd0);
        checkOutput("midrst_o_sel",   {30'b0, o_sel},   32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("after_rst_winner", {30'b0, o_sel}, 32'd0);

        // Random traffic, back-pressure and occasional resets.
        qClear();
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 3; c++) begin
                if (qSize(c) == 0 && $urandom_range(0, 2) != 0)
                    qPush(c, DW'($urandom), ($urandom_range(0, 3) == 0));
            end
            applyStimulus(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
